// File: rtl/sg_stream_smoother_if.sv
// Stream and coefficient bus of sg_stream_smoother.
// The slave modport is the smoother's own view; master is the view of the source/sink/config side.
interface sg_stream_smoother_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int WINDOW = 7,
    parameter int AW     = $clog2(WINDOW)
);
    logic                     s_valid;
    logic                     s_ready;
    logic signed [DATA_W-1:0] s_data;
    logic                     s_last;
    logic                     m_valid;
    logic                     m_ready;
    logic signed [DATA_W-1:0] m_data;
    logic                     m_last;
    logic                     coef_we;
    logic [AW-1:0]            coef_addr;
    logic signed [COEF_W-1:0] coef_wdata;

    modport slave (
        input  s_valid, s_data, s_last, m_ready, coef_we, coef_addr, coef_wdata,
        output s_ready, m_valid, m_data, m_last
    );

    modport master (
        output s_valid, s_data, s_last, m_ready, coef_we, coef_addr, coef_wdata,
        input  s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/sg_stream_smoother.sv
// Streaming Savitzky-Golay style FIR smoother, one MAC tap per cycle, edge samples replicated.
// Build option: define SG_SAT_EN to saturate the output instead of two's-complement wrap.
//
// state  | meaning
// IDLE   | waiting for the first sample of a frame
// PRIME  | filling the window's newer half (samples, then replicas after s_last)
// MAC    | accumulating WINDOW products
// OUT    | presenting the result until m_ready
// WAIT   | waiting for the next sample to slide the window
module sg_stream_smoother #(
    parameter int DATA_W     = 16,
    parameter int COEF_W     = 16,
    parameter int WINDOW     = 7,
    parameter int NORM_SHIFT = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sg_stream_smoother_if.slave  bus,
    output logic                 busy,
    output logic                 frame_done
);
    localparam int HALF   = (WINDOW - 1) / 2;
    localparam int AW     = $clog2(WINDOW);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = DATA_W + COEF_W + $clog2(WINDOW);
    localparam int CNT_W  = 16;

    typedef enum logic [2:0] {ST_IDLE, ST_PRIME, ST_MAC, ST_OUT, ST_WAIT} state_t;

    state_t state, state_nxt;

    logic signed [DATA_W-1:0] win  [WINDOW];
    logic signed [COEF_W-1:0] coef [WINDOW];
    logic signed [ACC_W-1:0]  acc;
    logic [AW-1:0]            tap_cnt;
    logic [AW-1:0]            prime_cnt;
    logic [CNT_W-1:0]         in_cnt;
    logic [CNT_W-1:0]         out_cnt;
    logic                     last_seen;
    logic signed [DATA_W-1:0] m_data_r;
    logic                     m_last_r;

    logic                     s_ready_c;
    logic                     in_acc;
    logic                     out_acc;
    logic                     load_all;
    logic                     shift_en;
    logic signed [DATA_W-1:0] shift_din;
    logic                     coef_wr;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  sum_nxt;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [DATA_W-1:0] result;

    assign bus.s_ready = s_ready_c;
    assign bus.m_valid = (state == ST_OUT);
    assign bus.m_data  = m_data_r;
    assign bus.m_last  = m_last_r && (state == ST_OUT);
    assign busy        = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        s_ready_c = 1'b0;
        in_acc    = 1'b0;
        out_acc   = 1'b0;
        load_all  = 1'b0;
        shift_en  = 1'b0;
        shift_din = win[WINDOW-1];
        case (state)
            ST_IDLE: begin
                s_ready_c = 1'b1;
                if (bus.s_valid) begin
                    in_acc    = 1'b1;
                    load_all  = 1'b1;
                    state_nxt = ST_PRIME;
                end
            end
            ST_PRIME: begin
                if (last_seen) begin
                    shift_en = 1'b1;
                end else begin
                    s_ready_c = 1'b1;
                    if (bus.s_valid) begin
                        in_acc    = 1'b1;
                        shift_en  = 1'b1;
                        shift_din = bus.s_data;
                    end
                end
                if (shift_en && prime_cnt == AW'(1)) state_nxt = ST_MAC;
            end
            ST_MAC: begin
                if (tap_cnt == '0) state_nxt = ST_OUT;
            end
            ST_OUT: begin
                if (bus.m_ready) begin
                    out_acc = 1'b1;
                    if (m_last_r) begin
                        state_nxt = ST_IDLE;
                    end else if (last_seen) begin
                        // past the end of the frame: slide in a copy of the last sample
                        shift_en  = 1'b1;
                        state_nxt = ST_MAC;
                    end else begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                s_ready_c = 1'b1;
                if (bus.s_valid) begin
                    in_acc    = 1'b1;
                    shift_en  = 1'b1;
                    shift_din = bus.s_data;
                    state_nxt = ST_MAC;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign coef_wr = (state == ST_IDLE) && bus.coef_we && !in_acc
                     && (int'(bus.coef_addr) < WINDOW);

    assign prod    = PROD_W'(win[tap_cnt]) * PROD_W'(coef[tap_cnt]);
    assign sum_nxt = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    assign shifted = sum_nxt >>> NORM_SHIFT;

`ifdef SG_SAT_EN
    logic signed [ACC_W-1:0] sat_max;
    logic signed [ACC_W-1:0] sat_min;
    assign sat_max = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    assign sat_min = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    always_comb begin
        result = shifted[DATA_W-1:0];
        if (shifted > sat_max)      result = sat_max[DATA_W-1:0];
        else if (shifted < sat_min) result = sat_min[DATA_W-1:0];
    end
`else
    assign result = shifted[DATA_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            acc        <= '0;
            tap_cnt    <= '0;
            prime_cnt  <= '0;
            in_cnt     <= '0;
            out_cnt    <= '0;
            last_seen  <= 1'b0;
            m_data_r   <= '0;
            m_last_r   <= 1'b0;
            frame_done <= 1'b0;
            for (int i = 0; i < WINDOW; i++) begin
                win[i]  <= '0;
                coef[i] <= (i == HALF) ? COEF_W'(1 << NORM_SHIFT) : '0;
            end
        end else begin
            state      <= state_nxt;
            frame_done <= out_acc && m_last_r;

            if (load_all) begin
                for (int i = 0; i < WINDOW; i++) win[i] <= bus.s_data;
            end else if (shift_en) begin
                for (int i = 0; i < WINDOW - 1; i++) win[i] <= win[i+1];
                win[WINDOW-1] <= shift_din;
            end

            if (coef_wr) coef[bus.coef_addr] <= bus.coef_wdata;

            if (load_all) begin
                in_cnt    <= CNT_W'(1);
                out_cnt   <= '0;
                last_seen <= bus.s_last;
                prime_cnt <= AW'(HALF);
            end else begin
                if (in_acc) begin
                    in_cnt <= in_cnt + CNT_W'(1);
                    if (bus.s_last) last_seen <= 1'b1;
                end
                if (out_acc) out_cnt <= out_cnt + CNT_W'(1);
                if (state == ST_PRIME && shift_en) prime_cnt <= prime_cnt - AW'(1);
            end

            if (state != ST_MAC && state_nxt == ST_MAC) begin
                tap_cnt <= AW'(WINDOW - 1);
            end else if (state == ST_MAC) begin
                tap_cnt <= tap_cnt - AW'(1);
            end

            if (state == ST_MAC) begin
                acc <= (tap_cnt == '0) ? '0 : sum_nxt;
                if (tap_cnt == '0) begin
                    m_data_r <= result;
                    // last_seen already includes an s_last accepted on the way into MAC
                    m_last_r <= last_seen && (out_cnt + CNT_W'(1) == in_cnt);
                end
            end
        end
    end
endmodule

// File: tb/tb_sg_stream_smoother.sv
// Directed self-checking bench for sg_stream_smoother (WINDOW=7, NORM_SHIFT=12).
module tb_sg_stream_smoother;
    logic clk;
    logic rst_n;
    logic busy;
    logic frame_done;

    int n_assert = 0;
    int n_fail   = 0;

    logic signed [15:0] din  [16];
    logic signed [15:0] dexp [16];

    sg_stream_smoother_if #(.DATA_W(16), .COEF_W(16), .WINDOW(7)) bus ();

    sg_stream_smoother #(.DATA_W(16), .COEF_W(16), .WINDOW(7), .NORM_SHIFT(12)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic set_coef(input int addr, input int val);
        @(negedge clk);
        bus.coef_we    = 1'b1;
        bus.coef_addr  = 3'(addr);
        bus.coef_wdata = 16'(val);
        @(negedge clk);
        bus.coef_we    = 1'b0;
    endtask

    task automatic set_all_coef(input int val);
        for (int k = 0; k < 7; k++) set_coef(k, val);
    endtask

    // Feeds din[0..n-1] as one frame and checks outputs against dexp[]; optional stall and coef clash.
    task automatic run_frame(input string tag, input int n, input int stall, input bit clash);
        int si = 0;
        int oi = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        logic signed [15:0] held;
        while (oi < n && cyc < 2000) begin
            @(negedge clk);
            bus.m_ready    = 1'b1;
            bus.s_valid    = (si < n);
            bus.s_data     = din[si];
            bus.s_last     = (si == n - 1);
            bus.coef_we    = clash && (si == 0);
            bus.coef_addr  = 3'd3;
            bus.coef_wdata = 16'sd0;
            if (bus.m_valid && oi == stall && !stalled) begin
                stalled     = 1'b1;
                held        = bus.m_data;
                bus.m_ready = 1'b0;
                bus.coef_we = 1'b1;
                repeat (10) begin
                    @(negedge clk);
                    check({tag, " stall m_data"}, 32'(bus.m_data), 32'(held));
                    check({tag, " stall s_ready"}, 32'(bus.s_ready), 32'd0);
                    check({tag, " stall m_valid"}, 32'(bus.m_valid), 32'd1);
                end
                bus.coef_we = 1'b0;
                bus.m_ready = 1'b1;
            end
            #1;
            if (bus.m_valid) begin
                check({tag, " m_data"}, 32'(bus.m_data), 32'(dexp[oi]));
                check({tag, " m_last"}, 32'(bus.m_last), 32'(oi == n - 1));
                oi++;
            end
            if (bus.s_valid && bus.s_ready) si++;
            cyc++;
        end
        if (oi < n) check({tag, " timeout outputs"}, 32'(oi), 32'(n));
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.coef_we = 1'b0;
        check({tag, " frame_done"}, 32'(frame_done), 32'd1);
        check({tag, " busy after"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, " frame_done pulse"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.s_valid    = 1'b0;
        bus.s_data     = '0;
        bus.s_last     = 1'b0;
        bus.m_ready    = 1'b0;
        bus.coef_we    = 1'b0;
        bus.coef_addr  = '0;
        bus.coef_wdata = '0;
        repeat (3) @(negedge clk);
        check("reset m_valid", 32'(bus.m_valid), 32'd0);
        check("reset m_data", 32'(bus.m_data), 32'd0);
        check("reset m_last", 32'(bus.m_last), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset frame_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle s_ready", 32'(bus.s_ready), 32'd1);

        // identity
        for (int i = 0; i < 5; i++) begin din[i] = 16'(10 * (i + 1)); dexp[i] = din[i]; end
        run_frame("identity", 5, -1, 1'b0);

        // single sample, coefficient write colliding with the accept must be dropped
        din[0] = 16'sd42; dexp[0] = 16'sd42;
        run_frame("single", 1, -1, 1'b1);

        // oldest tap only
        set_coef(3, 0);
        set_coef(0, 4096);
        for (int i = 0; i < 5; i++) din[i] = 16'(i + 1);
        dexp[0] = 16'sd1; dexp[1] = 16'sd1; dexp[2] = 16'sd1; dexp[3] = 16'sd1; dexp[4] = 16'sd2;
        run_frame("edge oldest", 5, -1, 1'b0);

        // newest tap only
        set_coef(0, 0);
        set_coef(6, 4096);
        dexp[0] = 16'sd4; dexp[1] = 16'sd5; dexp[2] = 16'sd5; dexp[3] = 16'sd5; dexp[4] = 16'sd5;
        run_frame("edge newest", 5, -1, 1'b0);

        // moving average 585/4096 per tap
        set_all_coef(585);
        for (int i = 0; i < 8; i++) begin din[i] = 16'sd700; dexp[i] = 16'sd699; end
        run_frame("movavg", 8, -1, 1'b0);

        // overflow of the 16-bit output
        set_all_coef(4096);
        for (int i = 0; i < 3; i++) begin
            din[i] = 16'sd30000;
`ifdef SG_SAT_EN
            dexp[i] = 16'sd32767;
`else
            dexp[i] = 16'sd13392;
`endif
        end
        run_frame("overflow", 3, -1, 1'b0);

        // reset in the middle of a frame
        @(negedge clk);
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = 16'sd5;
        bus.s_last  = 1'b0;
        repeat (6) @(negedge clk);
        check("midreset busy before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset m_valid", 32'(bus.m_valid), 32'd0);
        check("midreset m_last", 32'(bus.m_last), 32'd0);
        bus.s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // identity restored; backpressure with an ignored coefficient write during the stall
        for (int i = 0; i < 8; i++) begin
            din[i]  = 16'((i % 2 == 0) ? 100 * (i + 1) : -100 * (i + 1));
            dexp[i] = din[i];
        end
        run_frame("backpressure", 8, 3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
